// File: rtl/prim_rr_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prim_rr_reg_arbiter
// Description : One shared Width-bit register written by N requesters under
//               round-robin arbitration. The grant is a same-cycle handshake:
//               the winner's data is captured at the edge that ends its grant
//               cycle. An optional idle gap of MinGap cycles follows each
//               write so downstream consumers can settle.
// Ports       : clk_i      - clock, rising edge
//               rst_i      - synchronous active-high reset
//               clr_i      - synchronous clear of q_o to ResetValue
//               req_i      - per-requester write request (N)
//               wdata_i    - write data, requester i at [i*Width +: Width]
//               gnt_o      - one-hot grant, combinational (N)
//               q_o        - shared register value (Width)
//               upd_o      - one-cycle pulse when q_o shows new write data
//               upd_idx_o  - index of the last writer
//               busy_o     - high while the idle gap is running
// Revision    : 1.0 - initial release
// ============================================================================
module prim_rr_reg_arbiter #(
  parameter int unsigned       N          = 4,
  parameter int unsigned       Width      = 32,
  parameter logic [Width-1:0]  ResetValue = '0,
  parameter int unsigned       MinGap     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [N-1:0]          req_i,
  input  logic [N*Width-1:0]    wdata_i,
  output logic [N-1:0]          gnt_o,
  output logic [Width-1:0]      q_o,
  output logic                  upd_o,
  output logic [$clog2(N)-1:0]  upd_idx_o,
  output logic                  busy_o
);

  localparam int unsigned IDXW = $clog2(N);
  localparam int unsigned CNTW = 8;

  localparam logic [0:0] ST_ARB = 1'b0;
  localparam logic [0:0] ST_GAP = 1'b1;

  logic [0:0]       r_state;
  logic [IDXW-1:0]  r_ptr;
  logic [CNTW-1:0]  r_cnt;
  logic [Width-1:0] r_q;
  logic             r_upd;
  logic [IDXW-1:0]  r_upd_idx;

  logic             w_win_vld;
  logic [IDXW-1:0]  w_win_idx;
  logic [IDXW-1:0]  w_cand;
  int unsigned      w_sum;
  logic             w_arb_go;
  logic [Width-1:0] w_wdata;
  logic [IDXW-1:0]  w_ptr_nxt;

  // Rotating priority search: scan ptr, ptr+1, ... wrapping modulo N and
  // keep the first requester found.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = r_ptr;
    w_sum     = 0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N) begin
        w_sum = w_sum - N;
      end
      w_cand = IDXW'(w_sum);
      if (!w_win_vld && req_i[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

  // Clear and reset both suppress the grant in the cycle they are present.
  assign w_arb_go = (r_state == ST_ARB) && !rst_i && !clr_i && w_win_vld;

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (IDXW'(i) == w_win_idx) begin
        w_wdata = wdata_i[i*Width +: Width];
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == IDXW'(N-1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_ARB;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_q       <= ResetValue;
      r_upd     <= 1'b0;
      r_upd_idx <= '0;
    end else begin
      r_upd <= 1'b0;
      if (clr_i) begin
        r_q <= ResetValue;
      end
      if (r_state == ST_ARB) begin
        if (w_arb_go) begin
          r_q       <= w_wdata;
          r_ptr     <= w_ptr_nxt;
          r_upd     <= 1'b1;
          r_upd_idx <= w_win_idx;
          if (MinGap > 0) begin
            r_state <= ST_GAP;
            // Counter runs MinGap-1 down to 0, giving exactly MinGap idle cycles.
            r_cnt   <= CNTW'(MinGap - 1);
          end
        end
      end else begin
        if (r_cnt == '0) begin
          r_state <= ST_ARB;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign gnt_o     = w_arb_go ? (N'(1) << w_win_idx) : '0;
  assign q_o       = r_q;
  assign upd_o     = r_upd;
  assign upd_idx_o = r_upd_idx;
  assign busy_o    = (r_state == ST_GAP);

endmodule
`default_nettype wire
